// File: rtl/mac_pkg.sv
// Shared sizing helpers, default geometry and per-beat control bundle for the
// pipelined multiply-accumulate engine.
package mac_pkg;

    localparam int LANES_DEF = 16;
    localparam int DW_DEF    = 8;
    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 20;
    localparam int SH_W_DEF  = 5;

    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int tree_w(input int lanes, input int dw);
        return 2 * dw + $clog2(lanes);
    endfunction

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    // The default accumulator must hold a full tree sum without loss.
    localparam bit ACC_W_OK = ACC_W_DEF >= tree_w(LANES_DEF, DW_DEF);

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
        logic sgn;
    } beat_ctl_t;

endpackage

// File: rtl/mac_add_tree.sv
// Pairwise reduction of LANES equal-width operands with one output register.
// Sums wrap at W bits; W is sized by the caller so no information is lost.
module mac_add_tree
    import mac_pkg::*;
#(
    parameter int LANES = 16,
    parameter int W     = 20
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [LANES*W-1:0] ops_i,
    output logic [W-1:0]     sum_o
);

    // Heap-ordered nodes: leaves at LANES-1.., root at 0.
    logic [W-1:0] node [2*LANES-1];
    logic [W-1:0] sum_d;
    logic [W-1:0] sum_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_leaf
            assign node[LANES-1+gi] = ops_i[lane_lo(gi, W) +: W];
        end
        for (gi = 0; gi < LANES-1; gi++) begin : g_node
            assign node[gi] = node[2*gi+1] + node[2*gi+2];
        end
    endgenerate

    always_comb begin
        sum_d = node[0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/mac_acc_pipe.sv
// Four-register MAC pipeline: lane products, adder tree, framed accumulator,
// then shift/saturate to the output width on the last beat of each frame.
module mac_acc_pipe
    import mac_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SH_W  = SH_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                vld_i,
    input  logic                first_i,
    input  logic                last_i,
    input  logic                sgn_i,
    input  logic [SH_W-1:0]     shift_i,
    input  logic [LANES*DW-1:0] win,
    input  logic [LANES*DW-1:0] din,
    output logic [OUT_W-1:0]    acc_o,
    output logic                vld_o,
    output logic                sat_o
);

    localparam int PW     = prod_w(DW);
    localparam int TREE_W = tree_w(LANES, DW);

    localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] U_MAX = '1;

    beat_ctl_t s1_ctl_d, s1_ctl_q, s2_ctl_q;
    logic [SH_W-1:0] s1_shift_d, s1_shift_q, s2_shift_q, s3_shift_q;
    logic [LANES*PW-1:0]     prod_d, prod_q;
    logic [LANES*TREE_W-1:0] tree_ops;
    logic [TREE_W-1:0]       tree_sum;
    logic [ACC_W-1:0]        sum_ext, acc_d, acc_q;
    logic                    s3_fire_d, s3_fire_q, s3_sgn_d, s3_sgn_q;
    logic [ACC_W-1:0]        shr_s, shr_u, shifted;
    logic                    clip;
    logic [OUT_W-1:0]        acc_o_d, acc_o_q;
    logic                    sat_o_d, sat_o_q, vld_o_d, vld_o_q;

    always_comb begin
        s1_ctl_d       = '0;
        s1_ctl_d.vld   = vld_i;
        s1_ctl_d.first = vld_i & first_i;
        s1_ctl_d.last  = vld_i & last_i;
        s1_ctl_d.sgn   = sgn_i;
        s1_shift_d     = shift_i;
    end

    // Extending to PW before multiplying gives the exact product mod 2^PW.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PW-1:0] w_ext, a_ext;
            assign w_ext = sgn_i ? PW'($signed(win[lane_lo(gi, DW) +: DW]))
                                 : PW'(win[lane_lo(gi, DW) +: DW]);
            assign a_ext = sgn_i ? PW'($signed(din[lane_lo(gi, DW) +: DW]))
                                 : PW'(din[lane_lo(gi, DW) +: DW]);
            assign prod_d[gi*PW +: PW] = w_ext * a_ext;
            assign tree_ops[gi*TREE_W +: TREE_W] =
                s1_ctl_q.sgn ? TREE_W'($signed(prod_q[gi*PW +: PW]))
                             : TREE_W'(prod_q[gi*PW +: PW]);
        end
    endgenerate

    mac_add_tree #(
        .LANES (LANES),
        .W     (TREE_W)
    ) u_tree (
        .clk   (clk),
        .rstn  (rstn),
        .ops_i (tree_ops),
        .sum_o (tree_sum)
    );

    always_comb begin
        sum_ext = s2_ctl_q.sgn ? ACC_W'($signed(tree_sum)) : ACC_W'(tree_sum);
        acc_d   = acc_q;
        if (s2_ctl_q.vld) begin
            acc_d = s2_ctl_q.first ? sum_ext : acc_q + sum_ext;
        end
        s3_fire_d = s2_ctl_q.vld & s2_ctl_q.last;
        s3_sgn_d  = s2_ctl_q.sgn;
    end

    // Output stage reads the accumulator one cycle after the last beat lands.
    always_comb begin
        shr_s   = $signed(acc_q) >>> s3_shift_q;
        shr_u   = acc_q >> s3_shift_q;
        shifted = s3_sgn_q ? shr_s : shr_u;
        if (s3_sgn_q) begin
            clip = !((&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1]));
        end else begin
            clip = |shifted[ACC_W-1:OUT_W];
        end
        acc_o_d = acc_o_q;
        sat_o_d = sat_o_q;
        vld_o_d = s3_fire_q;
        if (s3_fire_q) begin
            sat_o_d = clip;
            if (!clip) begin
                acc_o_d = shifted[OUT_W-1:0];
            end else if (s3_sgn_q) begin
                acc_o_d = shifted[ACC_W-1] ? S_MIN : S_MAX;
            end else begin
                acc_o_d = U_MAX;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_ctl_q   <= '0;
            s1_shift_q <= '0;
            prod_q     <= '0;
            s2_ctl_q   <= '0;
            s2_shift_q <= '0;
            acc_q      <= '0;
            s3_fire_q  <= 1'b0;
            s3_sgn_q   <= 1'b0;
            s3_shift_q <= '0;
            acc_o_q    <= '0;
            sat_o_q    <= 1'b0;
            vld_o_q    <= 1'b0;
        end else begin
            s1_ctl_q   <= s1_ctl_d;
            s1_shift_q <= s1_shift_d;
            prod_q     <= prod_d;
            s2_ctl_q   <= s1_ctl_q;
            s2_shift_q <= s1_shift_q;
            acc_q      <= acc_d;
            s3_fire_q  <= s3_fire_d;
            s3_sgn_q   <= s3_sgn_d;
            s3_shift_q <= s2_shift_q;
            acc_o_q    <= acc_o_d;
            sat_o_q    <= sat_o_d;
            vld_o_q    <= vld_o_d;
        end
    end

    assign acc_o = acc_o_q;
    assign sat_o = sat_o_q;
    assign vld_o = vld_o_q;

endmodule
